// File: rtl/uart_rx_word.sv
// UART receiver: 2-flop synchroniser, 8N1 deserialiser and word packer.
// Bytes are packed first-received-in-MSB so a completed word matches flash
// read order. All strobes are single-cycle; there is no back-pressure.
module uart_rx_word #(
  parameter int DELAY_FRAMES  = 234,
  parameter int MEMORY_LENGTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       uart_rx,
  output logic [7:0]                 rxByte,
  output logic                       byteReady,
  output logic [MEMORY_LENGTH*8-1:0] rxData,
  output logic                       dataReady,
  output logic                       frameError
);

  localparam int WORD_W = MEMORY_LENGTH * 8;
  localparam int CNT_W  = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
  localparam int BC_W   = $clog2(MEMORY_LENGTH + 1);

  // Counter values at which a full bit time / half a bit time has elapsed.
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(DELAY_FRAMES / 2 - 1);
  localparam logic [BC_W-1:0]  WORD_BYTES = BC_W'(MEMORY_LENGTH);
  localparam logic [BC_W-1:0]  BC_ONE     = BC_W'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;

  // Append a byte at the least-significant lane, pushing earlier bytes up.
  function automatic logic [WORD_W-1:0] pack_byte(input logic [WORD_W-1:0] word,
                                                  input logic [7:0]        b);
    pack_byte = (word << 8) | WORD_W'(b);
  endfunction

  // Synchroniser and edge-detector history.
  logic              sync1_q;
  logic              sync2_q;
  logic              prev_q;

  // Control state.
  logic [2:0]        state_q,     state_d;
  logic [2:0]        bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0]  cyc_q,       cyc_d;
  logic [BC_W-1:0]   byte_cnt_q,  byte_cnt_d;

  // Datapath state.
  logic [7:0]        shift_q,     shift_d;
  logic [WORD_W-1:0] word_q,      word_d;
  logic [7:0]        rx_byte_q,   rx_byte_d;
  logic [WORD_W-1:0] rx_data_q,   rx_data_d;
  logic              byte_rdy_q,  byte_rdy_d;
  logic              data_rdy_q,  data_rdy_d;
  logic              frame_err_q, frame_err_d;

  logic              bit_elapsed;
  logic              fall_edge;
  logic [WORD_W-1:0] word_next;
  logic [BC_W-1:0]   byte_cnt_inc;

  assign bit_elapsed  = (cyc_q == BIT_LAST);
  // prev_q follows rxSync in every state, so an edge arriving during COMMIT
  // is still seen on the first IDLE cycle; a line held low never re-fires.
  assign fall_edge    = prev_q & ~sync2_q;
  assign word_next    = pack_byte(word_q, shift_q);
  assign byte_cnt_inc = byte_cnt_q + BC_ONE;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next-state logic for the frame FSM, byte shifter and word packer.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cyc_d       = cyc_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    word_d      = word_q;
    rx_byte_d   = rx_byte_q;
    rx_data_d   = rx_data_q;
    byte_rdy_d  = 1'b0;
    data_rdy_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        cyc_d     = '0;
        bit_cnt_d = '0;
        if (fall_edge) begin
          state_d = START;
        end
      end

      START: begin
        // Re-check the line mid start bit to reject short glitches.
        if (cyc_q == HALF_LAST) begin
          cyc_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_elapsed) begin
          cyc_d     = '0;
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      STOP: begin
        if (bit_elapsed) begin
          cyc_d = '0;
          if (sync2_q) begin
            state_d = COMMIT;
          end else begin
            // Bad stop bit: the whole partial word is suspect, drop it.
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
            word_d      = '0;
            state_d     = IDLE;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      COMMIT: begin
        cyc_d      = '0;
        rx_byte_d  = shift_q;
        byte_rdy_d = 1'b1;
        if (byte_cnt_inc == WORD_BYTES) begin
          rx_data_d  = word_next;
          data_rdy_d = 1'b1;
          byte_cnt_d = '0;
          word_d     = '0;
        end else begin
          word_d     = word_next;
          byte_cnt_d = byte_cnt_inc;
        end
        state_d = IDLE;
      end

      default: begin
        cyc_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Register FSM, datapath and output state; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cyc_q       <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      rx_byte_q   <= '0;
      rx_data_q   <= '0;
      byte_rdy_q  <= 1'b0;
      data_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cyc_q       <= cyc_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      rx_byte_q   <= rx_byte_d;
      rx_data_q   <= rx_data_d;
      byte_rdy_q  <= byte_rdy_d;
      data_rdy_q  <= data_rdy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rxByte     = rx_byte_q;
  assign byteReady  = byte_rdy_q;
  assign rxData     = rx_data_q;
  assign dataReady  = data_rdy_q;
  assign frameError = frame_err_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Scoreboard bench for uart_rx_word with DELAY_FRAMES=8, MEMORY_LENGTH=2.
module tb_uart_rx_word;

  localparam int DF = 8;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          uart_rx = 1'b1;
  logic [7:0]    rxByte;
  logic          byteReady;
  logic [15:0]   rxData;
  logic          dataReady;
  logic          frameError;

  int passed = 0;
  int total  = 0;
  int br_count = 0;
  int dr_count = 0;
  int fe_count = 0;
  int hold_bad = 0;
  bit hold_en  = 1'b0;
  logic [15:0] hold_ref = '0;
  bit prev_br = 1'b0;
  bit prev_dr = 1'b0;
  bit prev_fe = 1'b0;

  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_words[$];

  uart_rx_word #(.DELAY_FRAMES(DF), .MEMORY_LENGTH(ML)) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .rxByte     (rxByte),
    .byteReady  (byteReady),
    .rxData     (rxData),
    .dataReady  (dataReady),
    .frameError (frameError)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: pops expectations as strobes appear.
  always @(negedge clk) begin
    if (reset) begin
      prev_br = 1'b0;
      prev_dr = 1'b0;
      prev_fe = 1'b0;
    end else begin
      if (prev_br || prev_dr || prev_fe) begin
        total++;
        if (byteReady !== 1'b0 || dataReady !== 1'b0 || frameError !== 1'b0)
          $display("FAIL strobe_width: br=%b dr=%b fe=%b, required all 0", byteReady, dataReady, frameError);
        else passed++;
      end
      if (byteReady === 1'b1) begin
        br_count++;
        total++;
        if (exp_bytes.size() == 0)
          $display("FAIL unexpected_byte: got %h, none expected", rxByte);
        else begin
          logic [7:0] eb;
          eb = exp_bytes.pop_front();
          if (rxByte !== eb) $display("FAIL rxByte: got %h, required %h", rxByte, eb);
          else passed++;
        end
      end
      if (dataReady === 1'b1) begin
        dr_count++;
        total++;
        if (exp_words.size() == 0)
          $display("FAIL unexpected_word: got %h, none expected", rxData);
        else begin
          logic [15:0] ew;
          ew = exp_words.pop_front();
          hold_ref = ew;
          if (rxData !== ew || byteReady !== 1'b1)
            $display("FAIL rxData: got %h br=%b, required %h br=1", rxData, byteReady, ew);
          else passed++;
        end
      end else if (hold_en && rxData !== hold_ref) begin
        hold_bad++;
      end
      if (frameError === 1'b1) begin
        fe_count++;
        total++;
        if (byteReady !== 1'b0 || dataReady !== 1'b0)
          $display("FAIL fe_exclusive: br=%b dr=%b, required 0 0", byteReady, dataReady);
        else passed++;
      end
      prev_br = byteReady;
      prev_dr = dataReady;
      prev_fe = frameError;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    wait_cycles(DF);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cycles(DF);
    end
    uart_rx = stop_bit;
    wait_cycles(DF);
    uart_rx = 1'b1;
  endtask

  task automatic check_queues_empty(input string tag);
    total++;
    if (exp_bytes.size() != 0 || exp_words.size() != 0)
      $display("FAIL %s_pending: bytes=%0d words=%0d, required 0 0", tag, exp_bytes.size(), exp_words.size());
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    uart_rx = 1'b1;
    wait_cycles(3);
    total++;
    if (rxByte !== 8'h00 || byteReady !== 1'b0 || rxData !== 16'h0000 ||
        dataReady !== 1'b0 || frameError !== 1'b0)
      $display("FAIL reset_outputs: byte=%h br=%b data=%h dr=%b fe=%b, required all 0",
               rxByte, byteReady, rxData, dataReady, frameError);
    else passed++;
    reset = 1'b0;
    wait_cycles(2 * DF);
  endtask

  task automatic test_single_word();
    int br0, dr0, fe0;
    br0 = br_count; dr0 = dr_count; fe0 = fe_count;
    exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h3C);
    exp_words.push_back(16'hA53C);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    wait_cycles(3 * DF);
    total++;
    if (br_count - br0 != 2 || dr_count - dr0 != 1 || fe_count - fe0 != 0)
      $display("FAIL single_word_counts: br=%0d dr=%0d fe=%0d, required 2 1 0",
               br_count - br0, dr_count - dr0, fe_count - fe0);
    else passed++;
    check_queues_empty("single_word");
  endtask

  task automatic test_glitch();
    int br0, dr0, fe0;
    br0 = br_count; dr0 = dr_count; fe0 = fe_count;
    uart_rx = 1'b0;
    wait_cycles(2);
    uart_rx = 1'b1;
    wait_cycles(3 * DF);
    total++;
    if (br_count != br0 || dr_count != dr0 || fe_count != fe0 || dut.state_q !== 3'd0)
      $display("FAIL glitch_reject: br=%0d dr=%0d fe=%0d state=%0d, required 0 0 0 0",
               br_count - br0, dr_count - dr0, fe_count - fe0, dut.state_q);
    else passed++;
    exp_bytes.push_back(8'h55); exp_bytes.push_back(8'h01);
    exp_words.push_back(16'h5501);
    send_frame(8'h55, 1'b1);
    send_frame(8'h01, 1'b1);
    wait_cycles(3 * DF);
    check_queues_empty("glitch");
  endtask

  task automatic test_frame_error();
    int dr0, fe0;
    dr0 = dr_count; fe0 = fe_count;
    exp_bytes.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b0);
    wait_cycles(3 * DF);
    total++;
    if (fe_count - fe0 != 1 || dr_count != dr0)
      $display("FAIL frame_error_counts: fe=%0d dr=%0d, required 1 0", fe_count - fe0, dr_count - dr0);
    else passed++;
    exp_bytes.push_back(8'h33); exp_bytes.push_back(8'h44);
    exp_words.push_back(16'h3344);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    wait_cycles(3 * DF);
    check_queues_empty("frame_error");
  endtask

  task automatic test_back_to_back();
    int dr0;
    dr0 = dr_count;
    for (int i = 1; i <= 4; i++) exp_bytes.push_back(8'(i));
    exp_words.push_back(16'h0102);
    exp_words.push_back(16'h0304);
    hold_ref = 16'h3344;
    hold_bad = 0;
    hold_en  = 1'b1;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    wait_cycles(3 * DF);
    hold_en = 1'b0;
    total++;
    if (dr_count - dr0 != 2 || hold_bad != 0)
      $display("FAIL back_to_back: dr=%0d hold_errors=%0d, required 2 0", dr_count - dr0, hold_bad);
    else passed++;
    check_queues_empty("back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'hFF;
    uart_rx = 1'b0;
    wait_cycles(DF);
    for (int i = 0; i < 3; i++) begin
      uart_rx = b[i];
      wait_cycles(DF);
    end
    uart_rx = b[3];
    wait_cycles(DF / 2);
    reset = 1'b1;
    wait_cycles(1);
    total++;
    if (rxByte !== 8'h00 || byteReady !== 1'b0 || rxData !== 16'h0000 ||
        dataReady !== 1'b0 || frameError !== 1'b0 || dut.state_q !== 3'd0)
      $display("FAIL reset_mid_frame: byte=%h br=%b data=%h dr=%b fe=%b state=%0d, required all 0",
               rxByte, byteReady, rxData, dataReady, frameError, dut.state_q);
    else passed++;
    reset = 1'b0;
    uart_rx = 1'b1;
    wait_cycles(12 * DF);
    exp_bytes.push_back(8'hDE); exp_bytes.push_back(8'hAD);
    exp_words.push_back(16'hDEAD);
    send_frame(8'hDE, 1'b1);
    send_frame(8'hAD, 1'b1);
    wait_cycles(3 * DF);
    check_queues_empty("reset_mid_frame");
  endtask

  task automatic test_reset_partial_word();
    exp_bytes.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    wait_cycles(2 * DF);
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(2 * DF);
    exp_bytes.push_back(8'hBE); exp_bytes.push_back(8'hEF);
    exp_words.push_back(16'hBEEF);
    send_frame(8'hBE, 1'b1);
    send_frame(8'hEF, 1'b1);
    wait_cycles(3 * DF);
    check_queues_empty("reset_partial_word");
  endtask

  task automatic test_break();
    int br0, fe0;
    br0 = br_count; fe0 = fe_count;
    uart_rx = 1'b0;
    wait_cycles(40 * DF);
    uart_rx = 1'b1;
    wait_cycles(2 * DF);
    total++;
    if (fe_count - fe0 != 1 || br_count != br0)
      $display("FAIL break_frame_error: fe=%0d br=%0d, required 1 0", fe_count - fe0, br_count - br0);
    else passed++;
    exp_bytes.push_back(8'h7E); exp_bytes.push_back(8'h81);
    exp_words.push_back(16'h7E81);
    send_frame(8'h7E, 1'b1);
    send_frame(8'h81, 1'b1);
    wait_cycles(3 * DF);
    total++;
    if (fe_count - fe0 != 1)
      $display("FAIL break_after: fe=%0d, required 1", fe_count - fe0);
    else passed++;
    check_queues_empty("break");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_partial_word();
    test_break();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- UART receiver; the receive-side counterpart of the team's uart transmitter.
- Samples the serial line, deserialises 8N1 frames, and packs MEMORY_LENGTH consecutive bytes into one word.
- Presents the word with a one-cycle ready strobe, letting the cpu or host load data over the same link the transmitter drives.
- Per-byte strobes and a framing-error flag are provided for debug and LED status.

Parameters:
- DELAY_FRAMES, 234, clk cycles per bit (27 MHz / 115200).
- MEMORY_LENGTH, 2, bytes per assembled word; legal range 1..16.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- uart_rx  input  1  asynchronous serial line; idles high.
- rxByte  output  8  last correctly framed byte.
- byteReady  output  1  one-cycle strobe; rxByte is updated in the same cycle.
- rxData  output  MEMORY_LENGTH*8  assembled word; holds its value until the next word completes.
- dataReady  output  1  one-cycle strobe; rxData is valid in the same cycle.
- frameError  output  1  one-cycle strobe when a stop bit samples low.

Behaviour:
- Synchroniser:
  - uart_rx passes through 2 flops to give rxSync; both flops reset to 1.
  - All logic uses rxSync. Input-to-detection latency is 2 cycles.
- Reset state:
  - rxByte=0, byteReady=0, rxData=0, dataReady=0, frameError=0.
  - state=IDLE, bit counter=0, cycle counter=0, byte count=0, partial buffer=0.
- Cycle counter:
  - Clears on every state entry.
  - "Bit time elapsed" means counter==DELAY_FRAMES-1; the counter returns to 0 on that cycle.
- State machine:
  - IDLE: a falling edge of rxSync (previous sample 1, current 0) moves to START. A line held low never re-triggers.
  - START: wait until counter==DELAY_FRAMES/2-1 (integer division), then sample rxSync.
    - Sample 0: go to DATA.
    - Sample 1: treat as a glitch and return to IDLE with no strobes.
  - DATA: sample rxSync each time a bit time elapses, shifting LSB-first into the byte register. After the 8th sample, go to STOP.
  - STOP: sample when a bit time elapses.
    - Sample 1: go to COMMIT.
    - Sample 0: pulse frameError, discard the byte, clear byte count and the partial word, then return to IDLE.
  - COMMIT (1 cycle):
    - rxByte <= byte; pulse byteReady.
    - Shift the byte into the partial word. The first byte of a word ends up in the most-significant byte lane, matching flash read order.
    - Increment byte count.
    - If the count reaches MEMORY_LENGTH: rxData <= completed word, pulse dataReady, clear count. This happens in the same cycle as byteReady.
    - Return to IDLE.
- Latency:
  - The byteReady/dataReady strobe comes 1 cycle after the stop-bit sample.
  - The stop-bit sample falls approximately 9.5 bit times after the start edge.
- Strobes:
  - byteReady, dataReady and frameError are high for exactly one cycle and are never high together with frameError.
  - There is no back-pressure. A consumer must capture rxData within one word time; rxData is stable until the next dataReady.
- Back-to-back frames:
  - COMMIT returns to IDLE about half a bit before the next start edge.
  - A start edge arriving during COMMIT is detected on the first IDLE cycle, because the edge detector's previous-sample flop updates every cycle in every state.
- Reset mid-frame: discards any partial bit, byte or word. The outputs take their reset values on the next cycle.
- Widths: byte count is $clog2(MEMORY_LENGTH+1) bits; bit counter is 3 bits; cycle counter is $clog2(DELAY_FRAMES) bits.

Test Plan:
All benches use DELAY_FRAMES=8 and MEMORY_LENGTH=2 unless noted.
1. Single word: send frames 0xA5 then 0x3C.
   - byteReady pulses twice with rxByte=0xA5, then 0x3C.
   - dataReady pulses once, concurrent with the second byteReady, with rxData=0xA53C.
   - frameError stays 0.
2. Glitch rejection: pull uart_rx low for 2 cycles, then high.
   - No strobes; state returns to IDLE.
   - A following valid 0x55,0x01 pair yields rxData=0x5501.
3. Framing error:
   - Send 0x11, then 0x22 with its stop bit forced low. frameError pulses once, no dataReady.
   - Then send 0x33,0x44. rxData=0x3344, showing the partial word was discarded.
4. Back-to-back: send 4 frames 0x01,0x02,0x03,0x04 with zero idle time between stop and start bits.
   - Two dataReady pulses, rxData=0x0102 then 0x0304.
   - rxData holds 0x0102 until the second pulse.
5. Reset mid-frame: assert reset during the 4th data bit of the first byte of a word.
   - All outputs read 0 the next cycle.
   - A subsequent 0xDE,0xAD yields rxData=0xDEAD.
6. Line held low (break) for 40 bit times, then 0x7E,0x81: exactly one frameError pulse, then rxData=0x7E81.
